// File: rtl/pipe_pkg.sv
// Shared types, forwarding-select codes and the register-match helper
// used by the pipeline hazard controller.
package pipe_pkg;

   localparam int REG_AW_DEF = 5;
   // Shadow entries hold addresses at this width; narrower register files are zero-extended.
   localparam int REG_AW_MAX = 8;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef logic [REG_AW_MAX-1:0] haz_addr_t;

   typedef struct packed {
      logic      valid;
      haz_addr_t rd;
      haz_addr_t rs;
      haz_addr_t rt;
      logic      regwrite;
      logic      memread;
      logic      memwrite;
   } haz_entry_t;

   localparam haz_entry_t HAZ_ENTRY_NONE = '0;

   // Register 0 is hardwired zero, so a producer targeting it never matches.
   function automatic logic entry_match(input haz_entry_t e, input haz_addr_t src);
      return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
   endfunction

endpackage

// File: rtl/haz_fwd_sel.sv
// Two-level priority forwarding selector: the high-priority producer wins
// over the low-priority one, otherwise the register file is selected.
module haz_fwd_sel
   import pipe_pkg::*;
(
   input  haz_addr_t  src_i,
   input  haz_entry_t hi_i,
   input  logic       hi_en_i,
   input  haz_entry_t lo_i,
   input  logic       lo_en_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (hi_en_i && entry_match(hi_i, src_i)) begin
         sel_o = FWD_MEM;
      end else if (lo_en_i && entry_match(lo_i, src_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding and pipeline-enable control for the 5-stage CPU.
// Define HAZ_PERF_CNT_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_memwrite_i,
   input  logic              id_branch_i,
   input  logic              br_taken_i,
   input  logic              mem_ready_i,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              if_flush_o,
   output logic              id_ex_bubble_o,
   output logic              stage_en_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              fwd_id_a_o,
   output logic              fwd_id_b_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic              mem_timeout_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   haz_entry_t ex_q, ex_d;
   haz_entry_t mem_q, mem_d;
   haz_entry_t wb_q, wb_d;
   haz_entry_t id_entry;
   haz_addr_t  id_rs, id_rt;

   logic rs_hit_ex, rt_hit_ex, rs_hit_mem_ld, rt_hit_mem_ld;
   logic load_use, br_haz, mem_stall, haz_stall;
   logic mem_fwd_ok;

   logic [CNT_W-1:0] wait_q, wait_d;
   logic             timeout_q, timeout_d;

   assign id_rs = haz_addr_t'(id_rs_i);
   assign id_rt = haz_addr_t'(id_rt_i);

   always_comb begin
      id_entry = HAZ_ENTRY_NONE;
      if (id_valid_i) begin
         id_entry.valid    = 1'b1;
         id_entry.rd       = haz_addr_t'(id_rd_i);
         id_entry.rs       = id_rs;
         id_entry.rt       = id_rt;
         id_entry.regwrite = id_regwrite_i;
         id_entry.memread  = id_memread_i;
         id_entry.memwrite = id_memwrite_i;
      end
   end

   always_comb begin
      rs_hit_ex     = id_uses_rs_i && entry_match(ex_q, id_rs);
      rt_hit_ex     = id_uses_rt_i && entry_match(ex_q, id_rt);
      rs_hit_mem_ld = id_uses_rs_i && mem_q.memread && entry_match(mem_q, id_rs);
      rt_hit_mem_ld = id_uses_rt_i && mem_q.memread && entry_match(mem_q, id_rt);
      mem_stall     = mem_q.valid && (mem_q.memread || mem_q.memwrite) && !mem_ready_i;
      load_use      = id_valid_i && ex_q.memread && (rs_hit_ex || rt_hit_ex);
      // The ID comparator needs the value now, so any EX producer or a MEM load blocks it.
      br_haz        = id_branch_i && (rs_hit_ex || rt_hit_ex || rs_hit_mem_ld || rt_hit_mem_ld);
      haz_stall     = (load_use || br_haz) && !mem_stall;
   end

   always_comb begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_flush_o     = 1'b0;
      id_ex_bubble_o = 1'b0;
      stage_en_o     = 1'b1;
      ex_d           = ex_q;
      mem_d          = mem_q;
      wb_d           = wb_q;
      if (mem_stall) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         stage_en_o    = 1'b0;
      end else begin
         mem_d = ex_q;
         wb_d  = mem_q;
         if (haz_stall) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            ex_d           = HAZ_ENTRY_NONE;
         end else begin
            ex_d          = id_entry;
            if_flush_o    = id_branch_i && br_taken_i;
            if_id_write_o = !(id_branch_i && br_taken_i);
         end
      end
   end

   // Forwarding selectors: 0/1 = EX operands A/B, 2/3 = ID branch operands A/B.
   assign mem_fwd_ok = !mem_q.memread;

   haz_addr_t  fwd_src   [4];
   logic       fwd_hi_en [4];
   logic       fwd_lo_en [4];
   logic [1:0] fwd_sel   [4];

   always_comb begin
      fwd_src[0]   = ex_q.rs;
      fwd_src[1]   = ex_q.rt;
      fwd_src[2]   = id_rs;
      fwd_src[3]   = id_rt;
      fwd_hi_en[0] = mem_fwd_ok;
      fwd_hi_en[1] = mem_fwd_ok;
      fwd_hi_en[2] = id_branch_i && mem_fwd_ok;
      fwd_hi_en[3] = id_branch_i && mem_fwd_ok;
      fwd_lo_en[0] = 1'b1;
      fwd_lo_en[1] = 1'b1;
      fwd_lo_en[2] = 1'b0;
      fwd_lo_en[3] = 1'b0;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
         haz_fwd_sel u_sel (
            .src_i   (fwd_src[gi]),
            .hi_i    (mem_q),
            .hi_en_i (fwd_hi_en[gi]),
            .lo_i    (wb_q),
            .lo_en_i (fwd_lo_en[gi]),
            .sel_o   (fwd_sel[gi])
         );
      end
   endgenerate

   assign fwd_a_o    = fwd_sel[0];
   assign fwd_b_o    = fwd_sel[1];
   assign fwd_id_a_o = (fwd_sel[2] == FWD_MEM);
   assign fwd_id_b_o = (fwd_sel[3] == FWD_MEM);

   // Wait counter parks at the threshold so it can never wrap during a long stall.
   always_comb begin
      wait_d = '0;
      if (mem_stall) begin
         wait_d = (wait_q == TIMEOUT_CNT) ? wait_q : wait_q + CNT_W'(1);
      end
      timeout_d = timeout_q || (wait_d == TIMEOUT_CNT);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ex_q      <= HAZ_ENTRY_NONE;
         mem_q     <= HAZ_ENTRY_NONE;
         wb_q      <= HAZ_ENTRY_NONE;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_timeout_o = timeout_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((haz_stall || mem_stall) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle
// memory-stall / timeout / reset sequences, and a randomized run against a reference model.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW      = 5;
   localparam int CNT_W       = 16;
   localparam int MEM_TIMEOUT = 64;

`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic              id_valid_i, id_uses_rs_i, id_uses_rt_i;
   logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic              id_regwrite_i, id_memread_i, id_memwrite_i;
   logic              id_branch_i, br_taken_i, mem_ready_i;
   logic              pc_write_o, if_id_write_o, if_flush_o, id_ex_bubble_o, stage_en_o;
   logic [1:0]        fwd_a_o, fwd_b_o;
   logic              fwd_id_a_o, fwd_id_b_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic              mem_timeout_o;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
      .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i), .id_rd_i(id_rd_i),
      .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
      .id_branch_i(id_branch_i), .br_taken_i(br_taken_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_flush_o(if_flush_o),
      .id_ex_bubble_o(id_ex_bubble_o), .stage_en_o(stage_en_o),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .fwd_id_a_o(fwd_id_a_o), .fwd_id_b_o(fwd_id_b_o),
      .stall_cnt_o(stall_cnt_o), .mem_timeout_o(mem_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int v, rs, rt, urs, urt, rd, rw, mr, mw, br, tk, rdy;
   } id_in_t;

   typedef struct {
      id_in_t in;
      int pc, ifid, fl, bub, sen, fa, fb, fida, fidb;
   } vec_t;

   typedef struct {
      int v, rd, rs, rt, rw, mr, mw;
   } rec_t;

   int checks = 0;
   int errors = 0;

   function automatic id_in_t mk_in(int v, int rs, int rt, int urs, int urt, int rd,
                                    int rw, int mr, int mw, int br, int tk, int rdy);
      id_in_t x;
      x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.rd = rd;
      x.rw = rw; x.mr = mr; x.mw = mw; x.br = br; x.tk = tk; x.rdy = rdy;
      return x;
   endfunction

   function automatic vec_t mk_vec(id_in_t in, int pc, int ifid, int fl, int bub, int sen,
                                   int fa, int fb, int fida, int fidb);
      vec_t x;
      x.in = in; x.pc = pc; x.ifid = ifid; x.fl = fl; x.bub = bub; x.sen = sen;
      x.fa = fa; x.fb = fb; x.fida = fida; x.fidb = fidb;
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input id_in_t x);
      id_valid_i    = x.v[0];
      id_rs_i       = REG_AW'(x.rs);
      id_rt_i       = REG_AW'(x.rt);
      id_uses_rs_i  = x.urs[0];
      id_uses_rt_i  = x.urt[0];
      id_rd_i       = REG_AW'(x.rd);
      id_regwrite_i = x.rw[0];
      id_memread_i  = x.mr[0];
      id_memwrite_i = x.mw[0];
      id_branch_i   = x.br[0];
      br_taken_i    = x.tk[0];
      mem_ready_i   = x.rdy[0];
   endtask

   task automatic check_outs(input string tag, input vec_t x);
      chk({tag, ".pc_write"},  int'(pc_write_o),     x.pc);
      chk({tag, ".if_id_wr"},  int'(if_id_write_o),  x.ifid);
      chk({tag, ".if_flush"},  int'(if_flush_o),     x.fl);
      chk({tag, ".bubble"},    int'(id_ex_bubble_o), x.bub);
      chk({tag, ".stage_en"},  int'(stage_en_o),     x.sen);
      chk({tag, ".fwd_a"},     int'(fwd_a_o),        x.fa);
      chk({tag, ".fwd_b"},     int'(fwd_b_o),        x.fb);
      chk({tag, ".fwd_id_a"},  int'(fwd_id_a_o),     x.fida);
      chk({tag, ".fwd_id_b"},  int'(fwd_id_b_o),     x.fidb);
      $display("%s: pc=%0b ifid=%0b flush=%0b bub=%0b en=%0b fa=%0d fb=%0d fid=%0b%0b cnt=%0d tmo=%0b",
               tag, pc_write_o, if_id_write_o, if_flush_o, id_ex_bubble_o, stage_en_o,
               fwd_a_o, fwd_b_o, fwd_id_a_o, fwd_id_b_o, stall_cnt_o, mem_timeout_o);
   endtask

   task automatic apply_vec(input string tag, input vec_t x);
      @(negedge clk_i);
      drive(x.in);
      #1;
      check_outs(tag, x);
   endtask

   task automatic check_reset(input string tag);
      vec_t r;
      r = mk_vec(mk_in(0,0,0,0,0,0,0,0,0,0,0,1), 1,1,0,0,1, 0,0,0,0);
      check_outs(tag, r);
      chk({tag, ".stall_cnt"}, int'(stall_cnt_o), 0);
      chk({tag, ".timeout"},   int'(mem_timeout_o), 0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      drive(mk_in(0,0,0,0,0,0,0,0,0,0,0,1));
      rst_n_i = 1'b0;
      #1;
      check_reset("reset");
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   function automatic int wr(rec_t r, int src);
      return (r.v != 0 && r.rw != 0 && r.rd != 0 && r.rd == src) ? 1 : 0;
   endfunction

   id_in_t nop, nop_nr, lw2, add5, add3, sub6, add0, sub7, add4, beq4, lw8, add9, br9, sub12, x;
   vec_t   tbl[17];
   rec_t   stg[3], empty;
   bit     ms, hz, lu, bh, hit_ex, hit_ld;
   int     sc_m, run_m, tmo_m, e_fa, e_fb;

   initial begin
      nop    = mk_in(0, 0,0, 0,0,  0, 0,0,0, 0,0, 1);
      nop_nr = mk_in(0, 0,0, 0,0,  0, 0,0,0, 0,0, 0);
      lw2    = mk_in(1, 1,0, 1,0,  2, 1,1,0, 0,0, 1);
      add5   = mk_in(1, 2,3, 1,1,  5, 1,0,0, 0,0, 1);
      add3   = mk_in(1, 1,1, 1,1,  3, 1,0,0, 0,0, 1);
      sub6   = mk_in(1, 3,4, 1,1,  6, 1,0,0, 0,0, 1);
      add0   = mk_in(1, 1,1, 1,1,  0, 1,0,0, 0,0, 1);
      sub7   = mk_in(1, 0,0, 1,1,  7, 1,0,0, 0,0, 1);
      add4   = mk_in(1, 1,1, 1,1,  4, 1,0,0, 0,0, 1);
      beq4   = mk_in(1, 4,1, 1,1,  0, 0,0,0, 1,1, 1);
      lw8    = mk_in(1, 1,0, 1,0,  8, 1,1,0, 0,0, 1);
      add9   = mk_in(1, 1,1, 1,1,  9, 1,0,0, 0,0, 1);
      br9    = mk_in(1, 9,0, 1,0,  0, 0,0,0, 1,1, 0);
      sub12  = mk_in(1, 9,8, 1,1, 12, 1,0,0, 0,0, 1);

      //                      pc ifid fl bub sen fa fb fida fidb
      tbl[0]  = mk_vec(lw2,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk_vec(add5,  0, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[2]  = mk_vec(add5,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk_vec(nop,   1, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[4]  = mk_vec(nop,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[5]  = mk_vec(add3,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk_vec(sub6,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[7]  = mk_vec(nop,   1, 1, 0, 0, 1, 2, 0, 0, 0);
      tbl[8]  = mk_vec(add0,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[9]  = mk_vec(sub7,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[10] = mk_vec(nop,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[11] = mk_vec(nop,   1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[12] = mk_vec(add4,  1, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk_vec(beq4,  0, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[14] = mk_vec(beq4,  1, 0, 1, 0, 1, 0, 0, 1, 0);
      tbl[15] = mk_vec(nop,   1, 1, 0, 0, 1, 1, 0, 0, 0);
      tbl[16] = mk_vec(nop,   1, 1, 0, 0, 1, 0, 0, 0, 0);

      drive(nop);
      #2;
      check_reset("reset0");
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Directed table: load-use, EX forwarding, rd=0 suppression, branch stall/flush.
      for (int i = 0; i < 17; i++) begin
         apply_vec($sformatf("tbl%0d", i), tbl[i]);
      end
      chk("tbl.stall_cnt", int'(stall_cnt_o), PERF ? 2 : 0);

      // Load in MEM held for three cycles; a hazarding taken branch in ID must not win.
      do_reset();
      apply_vec("mem0", mk_vec(lw8,   1, 1, 0, 0, 1, 0, 0, 0, 0));
      apply_vec("mem1", mk_vec(add9,  1, 1, 0, 0, 1, 0, 0, 0, 0));
      apply_vec("mem2", mk_vec(br9,   0, 0, 0, 0, 0, 0, 0, 0, 0));
      apply_vec("mem3", mk_vec(br9,   0, 0, 0, 0, 0, 0, 0, 0, 0));
      apply_vec("mem4", mk_vec(br9,   0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("mem4.timeout", int'(mem_timeout_o), 0);
      apply_vec("mem5", mk_vec(sub12, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      chk("mem5.stall_cnt", int'(stall_cnt_o), PERF ? 3 : 0);
      apply_vec("mem6", mk_vec(nop,   1, 1, 0, 0, 1, 2, 1, 0, 0));
      chk("mem6.stall_cnt", int'(stall_cnt_o), PERF ? 3 : 0);

      // Long memory wait: timeout appears after 64 wait cycles and sticks.
      do_reset();
      apply_vec("tmo_ld", mk_vec(lw8, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      apply_vec("tmo_nx", mk_vec(nop, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k <= 70; k++) begin
         @(negedge clk_i);
         drive(nop_nr);
         #1;
         chk($sformatf("tmo%0d.timeout", k),  int'(mem_timeout_o), (k >= MEM_TIMEOUT) ? 1 : 0);
         chk($sformatf("tmo%0d.stage_en", k), int'(stage_en_o), 0);
         chk($sformatf("tmo%0d.stall_cnt", k), int'(stall_cnt_o), PERF ? k : 0);
         $display("tmo%0d: en=%0b pc=%0b tmo=%0b cnt=%0d", k, stage_en_o, pc_write_o,
                  mem_timeout_o, stall_cnt_o);
      end
      // Asynchronous reset in the middle of the stall, away from any clock edge.
      #1;
      rst_n_i = 1'b0;
      #1;
      check_reset("rst_mid_stall");
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Randomized run against the reference model.
      do_reset();
      empty = '{default: 0};
      for (int s = 0; s < 3; s++) stg[s] = empty;
      sc_m = 0; run_m = 0; tmo_m = 0;
      for (int n = 0; n < 1200; n++) begin
         x.v   = ($urandom_range(0, 7) != 0) ? 1 : 0;
         x.rs  = int'($urandom_range(0, 3));
         x.rt  = int'($urandom_range(0, 3));
         x.urs = int'($urandom_range(0, 1));
         x.urt = int'($urandom_range(0, 1));
         x.rd  = int'($urandom_range(0, 3));
         x.rw  = int'($urandom_range(0, 1));
         x.mr  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         x.mw  = (x.mr == 0 && $urandom_range(0, 4) == 0) ? 1 : 0;
         x.br  = ($urandom_range(0, 4) == 0) ? 1 : 0;
         x.tk  = int'($urandom_range(0, 1));
         x.rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
         @(negedge clk_i);
         drive(x);
         #1;
         ms     = (stg[1].v != 0) && (stg[1].mr != 0 || stg[1].mw != 0) && (x.rdy == 0);
         hit_ex = (x.urs != 0 && wr(stg[0], x.rs) != 0) || (x.urt != 0 && wr(stg[0], x.rt) != 0);
         hit_ld = (stg[1].mr != 0) &&
                  ((x.urs != 0 && wr(stg[1], x.rs) != 0) || (x.urt != 0 && wr(stg[1], x.rt) != 0));
         lu     = (x.v != 0) && (stg[0].mr != 0) && hit_ex;
         bh     = (x.br != 0) && (hit_ex || hit_ld);
         hz     = (lu || bh) && !ms;
         e_fa   = (wr(stg[1], stg[0].rs) != 0 && stg[1].mr == 0) ? 2 : (wr(stg[2], stg[0].rs) != 0 ? 1 : 0);
         e_fb   = (wr(stg[1], stg[0].rt) != 0 && stg[1].mr == 0) ? 2 : (wr(stg[2], stg[0].rt) != 0 ? 1 : 0);
         check_outs($sformatf("rnd%0d", n), mk_vec(x,
            (ms || hz) ? 0 : 1,
            (ms || hz || (x.br != 0 && x.tk != 0)) ? 0 : 1,
            (!ms && !hz && x.br != 0 && x.tk != 0) ? 1 : 0,
            hz ? 1 : 0,
            ms ? 0 : 1,
            e_fa, e_fb,
            (x.br != 0 && stg[1].mr == 0 && wr(stg[1], x.rs) != 0) ? 1 : 0,
            (x.br != 0 && stg[1].mr == 0 && wr(stg[1], x.rt) != 0) ? 1 : 0));
         chk($sformatf("rnd%0d.stall_cnt", n), int'(stall_cnt_o), PERF ? sc_m : 0);
         chk($sformatf("rnd%0d.timeout", n),   int'(mem_timeout_o), tmo_m);
         if (!ms) begin
            stg[2] = stg[1];
            stg[1] = stg[0];
            if (hz || x.v == 0) stg[0] = empty;
            else stg[0] = '{v: 1, rd: x.rd, rs: x.rs, rt: x.rt, rw: x.rw, mr: x.mr, mw: x.mw};
         end
         if (hz || ms) sc_m++;
         run_m = ms ? ((run_m < MEM_TIMEOUT) ? run_m + 1 : run_m) : 0;
         if (run_m == MEM_TIMEOUT) tmo_m = 1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the separate load-use detector and EX forwarding unit of the 5-stage pipeline.
- Keeps its own shadow scoreboard of the EX, MEM and WB stages (valid, dest, rs, rt, regwrite, memread, memwrite).
- Generates PC/IF-ID write enables, ID/EX bubble, IF flush, EX and ID-branch forwarding selects, and a global freeze for a variable-latency data memory with ready handshake.
- Sits beside the ID stage; every pipeline register enable in the CPU comes from this block.

Parameters:
- REG_AW, 5, register-address width; register 0 is hardwired zero.
- CNT_W, 16, width of the stall counter and the memory-wait counter.
- MEM_TIMEOUT, 64, consecutive wait cycles before mem_timeout_o sets; must be less than 2^CNT_W.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- id_valid_i  in  1  IF/ID holds a real instruction
- id_rs_i  in  REG_AW  ID source rs
- id_rt_i  in  REG_AW  ID source rt
- id_uses_rs_i  in  1  ID instruction reads rs
- id_uses_rt_i  in  1  ID instruction reads rt
- id_rd_i  in  REG_AW  ID destination, after RegDst selection
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- id_memwrite_i  in  1  ID instruction is a store
- id_branch_i  in  1  ID instruction is a branch, compared in ID
- br_taken_i  in  1  ID comparator result, after forwarding
- mem_ready_i  in  1  data memory has completed the MEM-stage access this cycle
- pc_write_o  out  1  PC enable
- if_id_write_o  out  1  IF/ID enable
- if_flush_o  out  1  clear IF/ID at the next edge
- id_ex_bubble_o  out  1  load zero control bits into ID/EX
- stage_en_o  out  1  enable for ID/EX, EX/MEM and MEM/WB
- fwd_a_o  out  2  EX operand A select: 00 register file, 01 WB, 10 MEM
- fwd_b_o  out  2  EX operand B select, same encoding
- fwd_id_a_o  out  1  branch operand A taken from the MEM ALU result
- fwd_id_b_o  out  1  branch operand B taken from the MEM ALU result
- stall_cnt_o  out  CNT_W  saturating count of stall cycles
- mem_timeout_o  out  1  sticky memory-timeout flag

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - ex_q, mem_q and wb_q valid bits clear; counters clear; mem_timeout_o = 0.
  - With all shadows invalid: pc_write_o = 1, if_id_write_o = 1, stage_en_o = 1, id_ex_bubble_o = 0, if_flush_o = 0, all forward selects = 0.
  - Reset mid-stall releases the stall immediately.
- Match rule: an entry matches a source register when the entry is valid, has regwrite = 1, has rd != 0, and rd equals the source. Register 0 never matches.
- mem_stall:
  - Asserted when mem_q is valid, mem_q is a load or store, and mem_ready_i = 0.
  - While asserted: stage_en_o = 0, pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 0, if_flush_o = 0, all shadows hold.
  - mem_stall has priority over every other condition.
- load_use: ex_q is a load and matches a used ID source (id_valid_i = 1).
- br_haz: id_branch_i = 1 and a used source matches either ex_q (any regwrite) or a load in mem_q.
- Hazard stall:
  - Applies when load_use or br_haz holds and mem_stall does not.
  - pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1, stage_en_o = 1.
  - At the edge ex_q loads an invalid entry; mem_q and wb_q advance.
- Branch flush:
  - if_flush_o = id_branch_i & br_taken_i & ~hazard stall & ~mem_stall.
  - Flush takes priority over if_id_write_o; the PC still writes.
- Normal advance:
  - ex_q loads the ID fields when id_valid_i = 1, otherwise loads an invalid entry.
  - mem_q takes ex_q; wb_q takes mem_q.
- EX forwarding:
  - fwd_a_o = 10 if mem_q matches ex_q.rs and is not a load.
  - Otherwise fwd_a_o = 01 if wb_q matches ex_q.rs.
  - Otherwise fwd_a_o = 00.
  - MEM has priority over WB. fwd_b_o follows the same rules using ex_q.rt.
- ID forwarding: fwd_id_a_o = 1 when id_branch_i = 1, mem_q matches id_rs_i, and mem_q is not a load. fwd_id_b_o is the same using id_rt_i.
- Combinational outputs: all forward selects and enables are combinational from the shadows and ID inputs, so they add zero latency.
- Memory wait counter and timeout:
  - Increments each mem_stall cycle and clears on any cycle without mem_stall.
  - When it reaches MEM_TIMEOUT, mem_timeout_o sets and stays set until reset. The pipeline keeps waiting.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: stall_cnt_o increments by 1 on every cycle with a hazard stall or mem_stall and saturates at all-ones.
- Not defined: stall_cnt_o is tied to 0 and no counter flops exist.
- mem_timeout_o is present in both builds.

Decomposition:
- Shared package pipe_pkg:
  - Constants REG_AW_DEF and FWD_RF/FWD_WB/FWD_MEM (00/01/10).
  - Typedef haz_entry_t {valid, rd, rs, rt, regwrite, memread, memwrite}.
- Sub-module haz_fwd_sel: one combinational priority selector, instantiated four times (EX A, EX B, ID A, ID B).

Test Plan:
- Load writing r2 issued, then add reading r2 -> exactly 1 cycle with pc_write_o = 0 and id_ex_bubble_o = 1; next cycle fwd_a_o = 01.
- add r3 back-to-back with sub reading r3 -> fwd_a_o = 10, no stall. With add rd = 0 instead -> fwd_a_o = 00.
- beq r4 immediately after an add writing r4 -> 1 stall cycle; then fwd_id_a_o = 1. With br_taken_i = 1 -> if_flush_o = 1 for 1 cycle.
- Load in MEM with mem_ready_i low for 3 cycles -> stage_en_o = 0 for exactly 3 cycles, shadows unchanged; stall_cnt_o = 3 when HAZ_PERF_CNT_EN is defined, 0 otherwise.
- mem_ready_i held low for 64 cycles -> mem_timeout_o = 1 from cycle 64 and stays set. Assert rst_n_i low -> all outputs return to reset values asynchronously.
